// File: rtl/dram_bist_seq.sv
// Pattern sequencer and checker for a single 2**ADDR_W x 1 distributed RAM.
// A run fills the RAM with one of four 1-bit patterns (unless check-only is
// selected), then sweeps a readback against the same pattern and reports
// pass/fail, the mismatch count and the lowest failing address.
module dram_bist_seq #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              check_only,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_d,
    output logic              ram_we,
    input  logic              ram_o,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_inc;
    logic [1:0]        mode_q;
    logic              check_only_q;
    logic              at_last;
    logic              launch;
    logic              mismatch;

    // Expected RAM bit for a given pattern mode and address.
    function automatic logic pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a);
        logic bit_v;
        bit_v = 1'b0;
        case (m)
            2'd0:    bit_v = 1'b0;
            2'd1:    bit_v = 1'b1;
            2'd2:    bit_v = a[0];
            default: bit_v = ^a;
        endcase
        return bit_v;
    endfunction

    // The address register drives the RAM directly, so ram_a is a flop output.
    assign ram_a    = addr;
    assign addr_inc = addr + 1'b1;
    assign at_last  = (addr == LAST_ADDR);
    assign launch   = (state == S_IDLE) && start;
    // The RAM read is asynchronous, so ram_o already reflects addr this cycle.
    assign mismatch = (state == S_READ) && (ram_o != pattern(mode_q, addr));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with <= so every flop samples the
        // pre-edge values of the others, independent of block ordering.
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the state-derived status outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = check_only ? S_READ : S_WRITE;
                end
            end
            S_WRITE: begin
                busy = 1'b1;
                if (at_last) begin
                    state_next = S_READ;
                end
            end
            S_READ: begin
                busy = 1'b1;
                if (at_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Run configuration: captured only when a run is launched from IDLE, so
    // input changes while busy have no effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= 2'd0;
            check_only_q <= 1'b0;
        end else if (launch) begin
            mode_q       <= mode;
            check_only_q <= check_only;
        end
    end

    // Address sweep: restarts at 0 on launch and steps once per busy cycle;
    // the natural ADDR_W-bit wrap takes it from DEPTH-1 back to 0 between
    // the write and read phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (launch) begin
            addr <= '0;
        end else if (state == S_WRITE || state == S_READ) begin
            addr <= addr_inc;
        end
    end

    // RAM write port: data and enable are registered alongside the address,
    // so each value is set up one edge ahead for the address it accompanies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we <= 1'b0;
            ram_d  <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            ram_d  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !check_only) begin
                        ram_we <= 1'b1;
                        ram_d  <= pattern(mode, '0);
                    end
                end
                S_WRITE: begin
                    if (!at_last && !check_only_q) begin
                        ram_we <= 1'b1;
                        ram_d  <= pattern(mode_q, addr_inc);
                    end
                end
                default: begin
                    ram_we <= 1'b0;
                    ram_d  <= 1'b0;
                end
            endcase
        end
    end

    // Readback scoring: count mismatches, remember the first one, and settle
    // the pass flag on the final compare so it is valid during the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            first_err <= '0;
            pass      <= 1'b0;
        end else if (launch) begin
            err_count <= '0;
            first_err <= '0;
            pass      <= 1'b0;
        end else if (state == S_READ) begin
            if (mismatch) begin
                err_count <= err_count + 1'b1;
                if (err_count == '0) begin
                    first_err <= addr;
                end
            end
            if (at_last) begin
                pass <= (err_count == '0) && !mismatch;
            end
        end
    end

endmodule

// File: tb/tb_dram_bist_seq.sv
// Self-checking bench for dram_bist_seq: a behavioural 128x1 RAM with
// loadable contents and stuck-at-0 cells, and a reference model that scores
// each run directly from the pattern definitions.
module tb_dram_bist_seq;

    localparam int ADDR_W = 7;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              start      = 1'b0;
    logic [1:0]        mode       = 2'd0;
    logic              check_only = 1'b0;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_d;
    logic              ram_we;
    logic              ram_o;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ADDR_W:0]   err_count;
    logic [ADDR_W-1:0] first_err;

    logic [DEPTH-1:0]  mem;
    logic [DEPTH-1:0]  load_img = '0;
    logic [DEPTH-1:0]  stuck    = '0;
    logic              load     = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dram_bist_seq #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .check_only (check_only),
        .ram_a      (ram_a),
        .ram_d      (ram_d),
        .ram_we     (ram_we),
        .ram_o      (ram_o),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_err  (first_err)
    );

    // RAM model: synchronous write, asynchronous read, optional stuck-at-0 cells.
    always @(posedge clk) begin
        if (load) mem <= load_img;
        else if (ram_we) mem[ram_a] <= ram_d;
    end
    assign ram_o = stuck[ram_a] ? 1'b0 : mem[ram_a];

    // Hang guard.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit pat(input int m, input int a);
        case (m)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return bit'(a % 2);
            default: return bit'($countones(a) % 2);
        endcase
    endfunction

    // Expected outcome of one run, from what the RAM ends up holding.
    function automatic void model(input int m, input bit co, input logic [DEPTH-1:0] img,
                                  input logic [DEPTH-1:0] stk, output int cnt, output int first);
        cnt   = 0;
        first = 0;
        for (int a = 0; a < DEPTH; a++) begin
            bit stored;
            bit seen;
            stored = co ? img[a] : pat(m, a);
            seen   = stk[a] ? 1'b0 : stored;
            if (seen != pat(m, a)) begin
                if (cnt == 0) first = a;
                cnt++;
            end
        end
    endfunction

    task automatic load_ram(input logic [DEPTH-1:0] img, input logic [DEPTH-1:0] stk);
        @(negedge clk);
        load_img = img;
        stuck    = stk;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    function automatic logic [DEPTH-1:0] rand_img();
        logic [DEPTH-1:0] v;
        for (int i = 0; i < DEPTH; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    // One complete run with inputs scrambled while busy.
    task automatic run(input int m, input bit co, input logic [DEPTH-1:0] img,
                       input logic [DEPTH-1:0] stk, input string tag);
        int   cnt, first, busy_n, we_n, done_at, wrong, exp_busy;
        bit   seen;
        logic p_cap;
        logic [ADDR_W:0]   e_cap;
        logic [ADDR_W-1:0] f_cap;
        load_ram(img, stk);
        model(m, co, img, stk, cnt, first);
        exp_busy   = co ? DEPTH : 2 * DEPTH;
        mode       = 2'(m);
        check_only = co;
        start      = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        busy_n  = 0;
        we_n    = 0;
        done_at = -1;
        seen    = 1'b0;
        p_cap   = 1'b0;
        e_cap   = '0;
        f_cap   = '0;
        for (int c = 0; c < 2 * DEPTH + 20 && !seen; c++) begin
            if (busy) busy_n++;
            if (ram_we) we_n++;
            if (done) begin
                seen    = 1'b1;
                done_at = c;
                p_cap   = pass;
                e_cap   = err_count;
                f_cap   = first_err;
                check({tag, "_busy_in_done"}, busy, 0);
            end
            mode       = 2'($urandom);
            check_only = 1'($urandom);
            @(negedge clk);
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_done_cycle"}, done_at, exp_busy);
        check({tag, "_busy_cycles"}, busy_n, exp_busy);
        check({tag, "_we_cycles"}, we_n, co ? 0 : DEPTH);
        check({tag, "_pass"}, p_cap, (cnt == 0) ? 1 : 0);
        check({tag, "_err_count"}, e_cap, cnt);
        check({tag, "_first_err"}, f_cap, first);
        wrong = 0;
        for (int a = 0; a < DEPTH; a++)
            if (mem[a] !== (co ? img[a] : pat(m, a))) wrong++;
        check({tag, "_ram_contents"}, wrong, 0);
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_pass_held"}, pass, p_cap);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        logic [DEPTH-1:0] stk55;
        int dones;
        int since;
        bit drained;
        stk55        = '0;
        stk55[8'h55] = 1'b1;

        // Power-on reset.
        #1;
        check("por_busy", busy, 0);
        check("por_done", done, 0);
        check("por_pass", pass, 0);
        check("por_err", err_count, 0);
        check("por_first", first_err, 0);
        check("por_we", ram_we, 0);
        check("por_a", ram_a, 0);
        check("por_d", ram_d, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("por_idle_busy", busy, 0);

        // Directed runs.
        run(2, 1'b0, rand_img(), '0, "fill_m2");
        run(2, 1'b1, DEPTH'(2), '0, "chk_init");
        run(1, 1'b0, rand_img(), stk55, "sa0_m1");
        run(0, 1'b0, rand_img(), stk55, "sa0_m0");
        run(3, 1'b0, rand_img(), stk55, "sa0_m3");

        // Randomized runs.
        for (int r = 0; r < 4; r++) begin
            logic [DEPTH-1:0] stk;
            stk = '0;
            stk[$urandom_range(0, DEPTH - 1)] = 1'b1;
            stk[$urandom_range(0, DEPTH - 1)] = 1'b1;
            run(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rand_img(), stk, "rand");
        end

        // Reset in the middle of the write phase.
        load_ram(rand_img(), '0);
        mode = 2'd2; check_only = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("rstw_we_before", ram_we, 1);
        check("rstw_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstw_we", ram_we, 0);
        check("rstw_busy", busy, 0);
        check("rstw_a", ram_a, 0);
        check("rstw_d", ram_d, 0);
        check("rstw_done", done, 0);
        check("rstw_pass", pass, 0);
        check("rstw_err", err_count, 0);
        check("rstw_first", first_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rstw_stays_idle", {busy, done}, 0);
        end

        // Reset in the middle of the read phase discards partial results.
        load_ram(rand_img(), stk55);
        mode = 2'd1; check_only = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (DEPTH + 8'h55 + 5) @(negedge clk);
        check("rstr_err_before", err_count, 1);
        check("rstr_first_before", first_err, 8'h55);
        check("rstr_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstr_err", err_count, 0);
        check("rstr_pass", pass, 0);
        check("rstr_first", first_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // start held high: runs repeat with one IDLE cycle between them.
        load_ram(rand_img(), stk55);
        mode = 2'd0; check_only = 1'b0; start = 1'b1;
        dones = 0;
        since = -1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (since >= 0) since++;
            if (since == 1) check("held_gap_idle", {busy, done}, 0);
            if (since == 2) check("held_gap_busy", busy, 1);
            if (done) begin
                dones++;
                since = 0;
                check("held_pass", pass, 1);
                check("held_err", err_count, 0);
                mode       = 2'd0;
                check_only = 1'b0;
            end else if (busy) begin
                mode       = 2'($urandom);
                check_only = 1'($urandom);
            end
        end
        start = 1'b0; mode = 2'd0; check_only = 1'b0;
        check("held_done_count", dones, 2);
        drained = 1'b0;
        for (int c = 0; c < 3 * DEPTH && !drained; c++) begin
            @(negedge clk);
            if (!busy && !done) drained = 1'b1;
        end
        check("held_drain", drained, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dram_bist_seq.md
Name: dram_bist_seq

Overview:
- Pattern sequencer and checker placed directly upstream of a single 2**ADDR_W x 1 distributed RAM (RAM128X1S-class primitive, one write port, asynchronous read).
- Drives the RAM address, data and write-enable, then sweeps a readback and compares the RAM output against the expected pattern.
- Reports pass/fail, mismatch count and first failing address to the board top (switches in, LEDs out).
- Check-only mode skips the fill, so the RAM's INIT contents can be verified after configuration.

Parameters:
- ADDR_W, 7, RAM address width; DEPTH = 2**ADDR_W (localparam).

Ports:
- clk  in  1  system clock; RAM WCLK is the same net.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; sampled only in IDLE.
- mode  in  2  pattern: 0 all-0, 1 all-1, 2 d=addr[0], 3 d=^addr (address parity).
- check_only  in  1  sampled with start; 1 = skip WRITE phase.
- ram_a  out  ADDR_W  RAM address (registered).
- ram_d  out  1  RAM write data (registered).
- ram_we  out  1  RAM write enable (registered).
- ram_o  in  1  RAM read data; combinational function of ram_a.
- busy  out  1  high in WRITE or READ.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  1 if the last run had zero mismatches; held until the next start.
- err_count  out  ADDR_W+1  mismatches in the last run, 0..DEPTH.
- first_err  out  ADDR_W  lowest mismatching address of the last run; 0 if none.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; all outputs 0. This includes ram_we, so a reset mid-WRITE drops the write enable immediately.
  - The internal addr counter, latched mode and latched check_only also clear.
- States: IDLE, WRITE, READ, DONE.
- IDLE:
  - ram_we=0.
  - On start=1 at an edge, latch mode and check_only, clear err_count/first_err/pass, set addr=0.
  - Go to WRITE, or to READ if check_only=1.
- WRITE, one address per cycle:
  - ram_a=addr, ram_d=pattern(mode,addr), ram_we=1. The RAM commits at the next edge.
  - addr increments each cycle. After addr=DEPTH-1: ram_we=0, addr wraps to 0, go to READ.
- READ, one address per cycle, ram_we=0:
  - ram_a=addr; ram_o is valid in the same cycle because the RAM read is asynchronous.
  - At each edge compare ram_o against pattern(mode,ram_a).
  - On mismatch: err_count+=1; if this is the first mismatch, first_err=ram_a.
  - After ram_a=DEPTH-1 is compared, go to DONE.
- DONE, one cycle:
  - done=1, pass=(err_count==0), busy=0, then IDLE.
- Timing (start sampled at edge k):
  - Full run: busy is high for cycles k+1..k+2*DEPTH; done is high in cycle k+2*DEPTH+1.
  - Check-only run: busy for k+1..k+DEPTH; done in cycle k+DEPTH+1.
- Boundaries:
  - start held high re-triggers only from IDLE, so back-to-back runs have one IDLE cycle between DONE and the next WRITE/READ.
  - start, mode and check_only changes while busy are ignored.
  - err_count reaches DEPTH without wrap; its width is ADDR_W+1.
  - The addr counter wraps exactly at DEPTH-1→0; no address is written or read twice in a phase.
  - Reset during READ discards partial results: pass=0, err_count=0.
- Width rules:
  - pattern(mode,a) is 1 bit.
  - ^a is the XOR reduction over all ADDR_W bits.

Test Plan:
- Reset: assert rst_n=0 mid-WRITE → ram_we=0 the same cycle (async); all outputs 0; after release the block stays in IDLE with busy=0.
- Fill + check, mode=2, ADDR_W=7, fault-free RAM model:
  - 128 writes with ram_d=a[0]; busy high for exactly 256 cycles.
  - Then done pulse, pass=1, err_count=0, first_err=0.
- Check-only, mode=2, against a RAM with INIT=128'b10 (only address 1 set):
  - err_count=63 (odd addresses 3..127 read 0), first_err=3, pass=0.
  - busy high for 128 cycles; ram_we never asserted.
- Stuck-at-0 on address 0x55, mode=1: err_count=1, first_err=0x55, pass=0.
- Stuck-at-0 on address 0x55, mode=0: pass=1.
- Stuck-at-0 on address 0x55, mode=3: 0x55 has even parity, so pass=1.
- start held high for 600 cycles, mode=0:
  - Runs repeat with one IDLE cycle between them.
  - Each run gives done once and pass=1.
  - mode toggled mid-run has no effect until the next start sampled in IDLE.
